// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache and D-cache requests onto one memory port, with a SERVE timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the D-cache wins ties.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_valid,
  output logic [31:0] i_req_data,
  output logic        i_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_wr_data,
  input  logic        d_req_valid,
  input  logic        d_req_wr,
  output logic [31:0] d_req_data,
  output logic        d_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_req_valid,
  output logic        mem_req_wr,
  input  logic [31:0] mem_req_data,
  input  logic        mem_req_ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_wr_q, mem_wr_d;
  logic             mem_valid_q, mem_valid_d;
  logic [31:0]      i_data_q, i_data_d;
  logic [31:0]      d_data_q, d_data_d;
  logic             i_ready_q, i_ready_d;
  logic             d_ready_q, d_ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             d_wins_c;

`ifdef ARB_ROUND_ROBIN_EN
  // last_i_q = 1 when the I-cache held the most recent grant; reset value means "D last".
  logic last_i_q, last_i_d;

  assign d_wins_c = d_req_valid && (!i_req_valid || last_i_q);

  always_comb begin
    last_i_d = last_i_q;
    if (state_q == IDLE && (i_req_valid || d_req_valid)) begin
      last_i_d = !d_wins_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_i_q <= 1'b0;
    end else begin
      last_i_q <= last_i_d;
    end
  end
`else
  assign d_wins_c = d_req_valid;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = mem_wr_q;
    i_data_d    = i_data_q;
    d_data_d    = d_data_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_wins_c) begin
          state_d     = SERVE_D;
          mem_addr_d  = d_req_addr;
          mem_wr_d    = d_req_wr;
          mem_wdata_d = d_wr_data;
        end else if (i_req_valid) begin
          state_d     = SERVE_I;
          mem_addr_d  = i_req_addr;
          mem_wr_d    = 1'b0;
          mem_wdata_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_req_ready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = !mem_req_ready;
          if (state_q == SERVE_I) begin
            i_ready_d = 1'b1;
            i_data_d  = mem_req_ready ? mem_req_data : '0;
          end else begin
            d_ready_d = 1'b1;
            if (!mem_req_ready) begin
              d_data_d = '0;
            end else if (!mem_wr_q) begin
              d_data_d = mem_req_data;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    mem_valid_d = (state_d == SERVE_I) || (state_d == SERVE_D);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      i_data_q    <= '0;
      d_data_q    <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_valid_q <= mem_valid_d;
      i_data_q    <= i_data_d;
      d_data_q    <= d_data_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign i_req_data    = i_data_q;
  assign i_req_ready   = i_ready_q;
  assign d_req_data    = d_data_q;
  assign d_req_ready   = d_ready_q;
  assign mem_req_addr  = mem_addr_q;
  assign mem_wr_data   = mem_wdata_q;
  assign mem_req_wr    = mem_wr_q;
  assign mem_req_valid = mem_valid_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter; expected completions are queued at request
// time and popped when a ready pulse appears. Honours ARB_ROUND_ROBIN_EN for tie ordering.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_req_addr, i_req_data;
  logic        i_req_valid, i_req_ready;
  logic [31:0] d_req_addr, d_wr_data, d_req_data;
  logic        d_req_valid, d_req_wr, d_req_ready;
  logic [31:0] mem_req_addr, mem_wr_data, mem_req_data;
  logic        mem_req_valid, mem_req_wr, mem_req_ready;
  logic        busy, err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .i_req_addr(i_req_addr), .i_req_valid(i_req_valid),
    .i_req_data(i_req_data), .i_req_ready(i_req_ready),
    .d_req_addr(d_req_addr), .d_wr_data(d_wr_data),
    .d_req_valid(d_req_valid), .d_req_wr(d_req_wr),
    .d_req_data(d_req_data), .d_req_ready(d_req_ready),
    .mem_req_addr(mem_req_addr), .mem_wr_data(mem_wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .busy(busy), .err(err)
  );

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic [31:0] i_data;
    logic [31:0] d_data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_i, mdl_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Update the requester data model and queue the completion we expect to see.
  task automatic expect_txn(input logic is_d, input logic is_wr, input logic to,
                            input logic [31:0] rdata);
    exp_t e;
    if (to) begin
      if (is_d) mdl_d = '0; else mdl_i = '0;
    end else if (!is_wr) begin
      if (is_d) mdl_d = rdata; else mdl_i = rdata;
    end
    e.is_d   = is_d;
    e.err    = to;
    e.i_data = mdl_i;
    e.d_data = mdl_d;
    sb_q.push_back(e);
  endtask

  // Memory responder: answers in the (delay+1)th SERVE cycle; delay < 0 never answers.
  task automatic run_txn(input int delay, input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic exp_wr, input logic [31:0] exp_wdata, input int exp_serves,
                         input string tag);
    int guard, serves, busy_cyc, unstable;
    guard = 0; serves = 0; busy_cyc = 0; unstable = 0;
    while (!mem_req_valid && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_grant"}, 32'(mem_req_valid), 32'd1);
    if (!mem_req_valid) return;
    check({tag, "_addr"}, mem_req_addr, exp_addr);
    check({tag, "_wr"}, 32'(mem_req_wr), 32'(exp_wr));
    check({tag, "_wdata"}, mem_wr_data, exp_wdata);
    while (mem_req_valid && guard < 200) begin
      serves++;
      if (busy) busy_cyc++;
      if (mem_req_addr !== exp_addr || mem_req_wr !== exp_wr || mem_wr_data !== exp_wdata)
        unstable++;
      mem_req_ready = (delay >= 0) && (serves == delay + 1);
      mem_req_data  = rdata;
      @(negedge clk);
      guard++;
    end
    mem_req_ready = 1'b0;
    mem_req_data  = '0;
    check({tag, "_serves"}, 32'(serves), 32'(exp_serves));
    check({tag, "_stable"}, 32'(unstable), 32'd0);
    while (busy && guard < 300) begin
      busy_cyc++;
      @(negedge clk);
      guard++;
    end
    check({tag, "_busy"}, 32'(busy_cyc), 32'(exp_serves + 1));
  endtask

  // Scoreboard consumer: every ready pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (i_req_ready || d_req_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_ready", 32'({i_req_ready, d_req_ready}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ready_who", 32'({i_req_ready, d_req_ready}), e.is_d ? 32'd1 : 32'd2);
        check("ready_err", 32'(err), 32'(e.err));
        check("i_req_data", i_req_data, e.i_data);
        check("d_req_data", d_req_data, e.d_data);
      end
    end else if (err) begin
      check("err_without_ready", 32'(err), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        is_d;
    logic [31:0] rdata;
    rst = 1'b1;
    i_req_addr = '0; i_req_valid = 1'b0;
    d_req_addr = '0; d_wr_data = '0; d_req_valid = 1'b0; d_req_wr = 1'b0;
    mem_req_data = '0; mem_req_ready = 1'b0;
    mdl_i = '0; mdl_d = '0;

    #2 rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_readies", 32'({i_req_ready, d_req_ready, err}), 32'd0);
    check("rst_i_data", i_req_data, 32'd0);
    check("rst_d_data", d_req_data, 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // I-cache read, memory answers in the second SERVE cycle
    i_req_addr = 32'h0000_0040; i_req_valid = 1'b1;
    expect_txn(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    run_txn(1, 32'hDEAD_BEEF, 32'h40, 1'b0, 32'h0, 2, "i_rd");
    i_req_valid = 1'b0;

    // D-cache read at minimum latency
    d_req_addr = 32'h180; d_req_wr = 1'b0; d_wr_data = 32'h55AA_55AA; d_req_valid = 1'b1;
    expect_txn(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
    run_txn(0, 32'hCAFE_F00D, 32'h180, 1'b0, 32'h55AA_55AA, 1, "d_rd");
    d_req_valid = 1'b0;

    // D-cache write; d_req_data must keep the previous read value
    d_req_addr = 32'h100; d_req_wr = 1'b1; d_wr_data = 32'h1234_5678; d_req_valid = 1'b1;
    expect_txn(1'b1, 1'b1, 1'b0, 32'hBAD0_BAD0);
    run_txn(3, 32'hBAD0_BAD0, 32'h100, 1'b1, 32'h1234_5678, 4, "d_wr");
    d_req_valid = 1'b0; d_req_wr = 1'b0;

    // Timeout: memory never answers
    i_req_addr = 32'h400; i_req_valid = 1'b1;
    expect_txn(1'b0, 1'b0, 1'b1, 32'h0);
    run_txn(-1, 32'h1111_1111, 32'h400, 1'b0, 32'h0, 64, "i_to");
    i_req_valid = 1'b0;

    // Reset in the second SERVE_D cycle, D request still pending afterwards
    d_req_addr = 32'h200; d_req_wr = 1'b0; d_wr_data = 32'h0; d_req_valid = 1'b1;
    @(negedge clk);
    check("rst_mid_serve", 32'(mem_req_valid), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mid_mem_addr", mem_req_addr, 32'd0);
    check("rst_mid_d_data", d_req_data, 32'd0);
    mdl_i = '0; mdl_d = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_txn(1'b1, 1'b0, 1'b0, 32'h0BAD_CAFE);
    run_txn(0, 32'h0BAD_CAFE, 32'h200, 1'b0, 32'h0, 1, "rst_regrant");
    d_req_valid = 1'b0;

    // Both requesters valid through three transactions
    i_req_addr = 32'h80; d_req_addr = 32'h300; d_req_wr = 1'b0; d_wr_data = 32'h0;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      is_d  = RR ? (k == 1) : 1'b1;
      rdata = 32'hA000_0000 + 32'(k);
      expect_txn(is_d, 1'b0, 1'b0, rdata);
      run_txn(k, rdata, is_d ? 32'h300 : 32'h80, 1'b0, 32'h0, k + 1, "tie");
    end
    d_req_valid = 1'b0;
    expect_txn(1'b0, 1'b0, 1'b0, 32'h7777_0001);
    run_txn(0, 32'h7777_0001, 32'h80, 1'b0, 32'h0, 1, "tie_i_only");
    i_req_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, maximum number of SERVE cycles allowed without mem_req_ready before the transaction is aborted.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 i_req_addr  input  32  I-cache miss address.
REQ-005 i_req_valid  input  1  I-cache request; held high until i_req_ready.
REQ-006 i_req_data  output  32  read data returned to the I-cache.
REQ-007 i_req_ready  output  1  one-cycle completion pulse to the I-cache.
REQ-008 d_req_addr, d_wr_data  input  32 each  D-cache address and write data.
REQ-009 d_req_valid, d_req_wr  input  1 each  D-cache request, and 1=write / 0=read.
REQ-010 d_req_data  output  32  read data returned to the D-cache.
REQ-011 d_req_ready  output  1  one-cycle completion pulse to the D-cache.
REQ-012 mem_req_addr, mem_wr_data  output  32 each  memory address and write data.
REQ-013 mem_req_valid, mem_req_wr  output  1 each  memory request and write strobe.
REQ-014 mem_req_data  input  32  memory read data.
REQ-015 mem_req_ready  input  1  memory completion.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err  output  1  one-cycle pulse, coincident with the ready pulse, on timeout.

Function
REQ-018 FSM states SHALL be IDLE, SERVE_I, SERVE_D and DONE.
REQ-019 In IDLE with at least one valid request, the FSM SHALL move to the state for the winning requester at the next edge.
- At that same edge it SHALL latch the winner's address, wr and write data into mem_req_addr, mem_req_wr and mem_wr_data.
- mem_req_wr SHALL be 0 for an I-cache grant.
REQ-020 mem_req_valid SHALL be high in every SERVE_I/SERVE_D cycle and low in IDLE and DONE.
- mem_req_addr, mem_req_wr and mem_wr_data SHALL be stable throughout SERVE.
REQ-021 A SERVE cycle with mem_req_ready=1 SHALL, at the next edge, move the FSM to DONE and assert the winner's ready for exactly one cycle.
- On a read it SHALL also load mem_req_data into the winner's data output.
- On a write, d_req_data SHALL keep its previous value.
REQ-022 Non-winner outputs SHALL remain unchanged during a transaction.
- x_req_data SHALL hold its value until the next read completion for that requester.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE.
- Valid inputs SHALL be ignored in DONE, so a requester dropping valid after ready is never re-granted.
REQ-024 A SERVE cycle counter SHALL clear on entry to SERVE.
- If the counter reaches TIMEOUT-1 with mem_req_ready=0, the FSM SHALL go to DONE.
- The winner's ready SHALL pulse with err=1 and the winner's data output set to 0.
REQ-025 Minimum latency SHALL be two cycles: valid sampled at edge E0, mem_req_ready=1 in the first SERVE cycle, ready high in the cycle after E1.
REQ-026 Requests arriving during a transaction SHALL wait; they are arbitrated in the next IDLE.
REQ-027 mem_req_ready SHALL be ignored in IDLE and DONE.

Reset
REQ-028 While rst=0, asynchronously:
- state SHALL be IDLE;
- all outputs, the counter and the last-grant register SHALL be 0;
- any in-flight memory transaction SHALL be abandoned with no ready pulse.
REQ-029 Upon rst deassertion mid-request, a still-valid requester SHALL be arbitrated normally from IDLE.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined:
- when both requesters are valid in IDLE, the grant SHALL go to the requester not granted last;
- the last-grant register SHALL reset to D, so the I-cache wins the first tie;
- a single valid requester always wins.
REQ-031 Without ARB_ROUND_ROBIN_EN:
- the D-cache SHALL always win ties (fixed priority);
- no last-grant register SHALL exist.

Verification
REQ-032 I read only: i_req_valid=1, addr 0x0000_0040; memory returns 0xDEADBEEF with mem_req_ready one cycle after mem_req_valid -> mem_req_addr=0x40 and mem_req_wr=0; i_req_data=0xDEADBEEF; i_req_ready pulses once; busy for 3 cycles.
REQ-033 D write: d_req_wr=1, addr 0x100, data 0x12345678, ready after 3 cycles -> mem_req_wr=1 and mem_wr_data=0x12345678 for 4 SERVE cycles; d_req_ready pulses once; d_req_data unchanged.
REQ-034 Both valid on the same edge, held valid through three transactions:
- with ARB_ROUND_ROBIN_EN, grant order is I, D, I;
- without ARB_ROUND_ROBIN_EN, grant order is D, D, D until the D-cache drops valid.
REQ-035 TIMEOUT=64, mem_req_ready held 0 -> after 64 SERVE cycles, ready and err pulse together, data=0, FSM returns to IDLE.
REQ-036 rst pulled low in the 2nd SERVE_D cycle, then released with d_req_valid still 1 -> outputs 0 immediately; no d_req_ready pulse during reset; new grant to D after release.
